// File: rtl/instruction_set_pkg.sv
// Shared instruction-set types: word size, ALU flag vector, branch condition codes.
package instruction_set;

  localparam int WORD_SIZE = 16;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } FLAGS_T;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_EQ     = 4'd1,
    COND_NE     = 4'd2,
    COND_CS     = 4'd3,
    COND_CC     = 4'd4,
    COND_MI     = 4'd5,
    COND_PL     = 4'd6,
    COND_VS     = 4'd7,
    COND_VC     = 4'd8,
    COND_LT     = 4'd9,
    COND_GE     = 4'd10,
    COND_GT     = 4'd11,
    COND_LE     = 4'd12,
    COND_NEVER  = 4'd13
  } COND_T;

  typedef enum logic {
    BR_IDLE   = 1'b0,
    BR_RESULT = 1'b1
  } br_state_t;

  // Codes 14 and 15 are unassigned and evaluate to not-taken.
  function automatic logic cond_eval(input COND_T cond, input FLAGS_T f);
    logic lt;
    lt = f.n ^ f.v;
    case (cond)
      COND_ALWAYS: cond_eval = 1'b1;
      COND_EQ:     cond_eval = f.z;
      COND_NE:     cond_eval = ~f.z;
      COND_CS:     cond_eval = f.c;
      COND_CC:     cond_eval = ~f.c;
      COND_MI:     cond_eval = f.n;
      COND_PL:     cond_eval = ~f.n;
      COND_VS:     cond_eval = f.v;
      COND_VC:     cond_eval = ~f.v;
      COND_LT:     cond_eval = lt;
      COND_GE:     cond_eval = ~lt;
      COND_GT:     cond_eval = ~f.z & ~lt;
      COND_LE:     cond_eval = f.z | lt;
      default:     cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/condition_flags_unit_stack.sv
// LIFO of saved flag vectors; push/pop arrive already qualified as legal.
module flags_stack
  import instruction_set::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  FLAGS_T        data_in,
  output FLAGS_T        top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  FLAGS_T mem [DEPTH];
  logic [CW-1:0] top_ptr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_ptr = count - CW'(1);
  assign top     = mem[AW'(top_ptr)];

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push) begin
      count <= count + CW'(1);
    end else if (pop) begin
      count <= count - CW'(1);
    end
  end

  // Storage carries no reset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[AW'(count)] <= data_in;
    end
  end

endmodule

// File: rtl/condition_flags_unit.sv
// Flags register with save/restore stack and a two-state branch-condition evaluator.
module condition_flags_unit
  import instruction_set::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  FLAGS_T                           flags_in,
  input  logic                             flags_we,
  input  logic                             push,
  input  logic                             pop,
  input  COND_T                            cond,
  input  logic                             br_valid,
  output logic                             br_ready,
  output logic                             br_done,
  output logic                             br_taken,
  input  logic                             br_ack,
  output FLAGS_T                           flags_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_err
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  FLAGS_T    flags_q;
  FLAGS_T    flags_next;
  FLAGS_T    stack_top;
  logic      stack_full;
  logic      stack_empty;
  logic      push_ok;
  logic      pop_ok;
  logic      stack_fault;
  br_state_t state;
  br_state_t state_next;
  logic      accept;

  // Simultaneous push and pop is a conflict: neither happens.
  assign push_ok     = push & ~pop & ~stack_full;
  assign pop_ok      = pop & ~push & ~stack_empty;
  assign stack_fault = (push & pop) | (push & stack_full) | (pop & stack_empty);

  flags_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push_ok),
    .pop     (pop_ok),
    .data_in (flags_q),
    .top     (stack_top),
    .count   (stack_count),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  // A popped entry is discarded when flags_we overrides it.
  always_comb begin
    flags_next = flags_q;
    if (flags_we) begin
      flags_next = flags_in;
    end else if (pop_ok) begin
      flags_next = stack_top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= '0;
      stack_err <= 1'b0;
    end else begin
      flags_q <= flags_next;
      if (stack_fault) begin
        stack_err <= 1'b1;
      end
    end
  end

  assign flags_out = flags_q;

  // Handshake: a request is accepted on a cycle with br_valid && br_ready;
  // the result is presented with br_done and held until a cycle with br_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      BR_IDLE: begin
        if (br_valid) begin
          accept     = 1'b1;
          state_next = BR_RESULT;
        end
      end
      BR_RESULT: begin
        if (br_ack) begin
          state_next = BR_IDLE;
        end
      end
      default: state_next = BR_IDLE;
    endcase
  end

  // Evaluating against flags_next forwards a same-cycle flags write.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken <= 1'b0;
    end else if (accept) begin
      br_taken <= cond_eval(cond, flags_next);
    end
  end

  assign br_ready = (state == BR_IDLE) & ~rst;
  assign br_done  = (state == BR_RESULT);

  logic unused_cw;
  assign unused_cw = (CW == 0);

endmodule

// File: tb/tb_condition_flags_unit.sv
// Directed and randomized bench for condition_flags_unit with a queue-based reference model.
module tb_condition_flags_unit;
  import instruction_set::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  FLAGS_T        flags_in;
  logic          flags_we;
  logic          push;
  logic          pop;
  COND_T         cond;
  logic          br_valid;
  logic          br_ready;
  logic          br_done;
  logic          br_taken;
  logic          br_ack;
  FLAGS_T        flags_out;
  logic [CW-1:0] stack_count;
  logic          stack_err;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;
  logic       m_busy;
  logic       m_taken;

  condition_flags_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flags_in    (flags_in),
    .flags_we    (flags_we),
    .push        (push),
    .pop         (pop),
    .cond        (cond),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_done     (br_done),
    .br_taken    (br_taken),
    .br_ack      (br_ack),
    .flags_out   (flags_out),
    .stack_count (stack_count),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  // Branch semantics written as comparisons on the n/z/c/v flags.
  function automatic logic ref_taken(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic signed_less;
    {n, z, c, v} = f;
    signed_less = (n != v);
    case (code)
      4'd0:  ref_taken = 1'b1;
      4'd1:  ref_taken = (z == 1'b1);
      4'd2:  ref_taken = (z == 1'b0);
      4'd3:  ref_taken = (c == 1'b1);
      4'd4:  ref_taken = (c == 1'b0);
      4'd5:  ref_taken = (n == 1'b1);
      4'd6:  ref_taken = (n == 1'b0);
      4'd7:  ref_taken = (v == 1'b1);
      4'd8:  ref_taken = (v == 1'b0);
      4'd9:  ref_taken = signed_less;
      4'd10: ref_taken = !signed_less;
      4'd11: ref_taken = !signed_less && !z;
      4'd12: ref_taken = signed_less || z;
      default: ref_taken = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("flags_out", 8'(flags_out), 8'(m_flags));
    chk("stack_count", 8'(stack_count), 8'(m_stack.size()));
    chk("stack_err", 8'(stack_err), 8'(m_err));
    chk("br_done", 8'(br_done), 8'(m_busy));
    chk("br_ready", 8'(br_ready), 8'(!m_busy && !rst));
    if (m_busy) chk("br_taken", 8'(br_taken), 8'(m_taken));
  endtask

  // Advance the model by one edge from the current inputs, then compare.
  task automatic tick();
    logic [3:0] fn;
    logic [3:0] popped;
    logic       pop_done;
    pop_done = 1'b0;
    popped   = '0;
    if (rst) begin
      m_flags = '0;
      m_stack.delete();
      m_err   = 1'b0;
      m_busy  = 1'b0;
      m_taken = 1'b0;
    end else begin
      if (push && pop) m_err = 1'b1;
      else if (push) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_flags);
      end else if (pop) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else begin
          popped   = m_stack.pop_back();
          pop_done = 1'b1;
        end
      end
      fn = flags_we ? 4'(flags_in) : (pop_done ? popped : m_flags);
      if (!m_busy && br_valid) begin
        m_busy  = 1'b1;
        m_taken = ref_taken(4'(cond), fn);
      end else if (m_busy && br_ack) begin
        m_busy = 1'b0;
      end
      m_flags = fn;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst      = 1'b0;
    flags_in = '0;
    flags_we = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    cond     = COND_ALWAYS;
    br_valid = 1'b0;
    br_ack   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] vals [4];

  initial begin
    idle_inputs();
    m_flags = 'x; m_err = 1'b0; m_busy = 1'b0; m_taken = 1'b0;
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h4; vals[3] = 4'h8;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_flags", 8'(flags_out), 8'h00);
    chk("reset_count", 8'(stack_count), 8'h00);
    rst = 1'b0;

    // Same-cycle flags write forwarded into EQ evaluation
    flags_in = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
    flags_we = 1'b1; br_valid = 1'b1; cond = COND_EQ;
    tick();
    chk("fwd_done", 8'(br_done), 8'h01);
    chk("fwd_taken", 8'(br_taken), 8'h01);
    idle_inputs(); br_ack = 1'b1;
    tick();
    idle_inputs();

    // LT result held while br_ack stays low
    flags_in = '{n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b0}; flags_we = 1'b1;
    tick();
    idle_inputs(); br_valid = 1'b1; cond = COND_LT;
    tick();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_taken", 8'(br_taken), 8'h01);
      chk("hold_done", 8'(br_done), 8'h01);
      chk("hold_ready", 8'(br_ready), 8'h00);
    end
    br_ack = 1'b1;
    tick();
    idle_inputs();

    // Overflow then LIFO restore with a final underflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      flags_in = FLAGS_T'(vals[i]); flags_we = 1'b1;
      tick();
      flags_we = 1'b0; push = 1'b1;
      tick();
      push = 1'b0;
    end
    flags_in = FLAGS_T'(4'hF); flags_we = 1'b1;
    tick();
    flags_we = 1'b0; push = 1'b1;
    tick();
    push = 1'b0;
    chk("ovf_count", 8'(stack_count), 8'h04);
    chk("ovf_err", 8'(stack_err), 8'h01);
    for (int i = 0; i < 5; i++) begin
      pop = 1'b1;
      tick();
      chk("lifo_flags", 8'(flags_out), 8'(vals[(i < 4) ? 3 - i : 0]));
    end
    pop = 1'b0;

    // Push/pop conflict at count 2
    do_reset();
    push = 1'b1;
    tick();
    tick();
    pop = 1'b1;
    tick();
    idle_inputs();
    chk("conflict_count", 8'(stack_count), 8'h02);
    chk("conflict_err", 8'(stack_err), 8'h01);

    // Reset while a result is pending
    flags_in = FLAGS_T'(4'h6); flags_we = 1'b1; br_valid = 1'b1; push = 1'b1;
    tick();
    idle_inputs(); rst = 1'b1;
    tick();
    chk("rst_done", 8'(br_done), 8'h00);
    chk("rst_flags", 8'(flags_out), 8'h00);
    chk("rst_count", 8'(stack_count), 8'h00);
    chk("rst_err", 8'(stack_err), 8'h00);
    rst = 1'b0;

    // Every condition code against every flag combination
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        idle_inputs();
        flags_in = FLAGS_T'(4'(f)); flags_we = 1'b1;
        cond = COND_T'(4'(c)); br_valid = 1'b1;
        tick();
        idle_inputs(); br_ack = 1'b1;
        tick();
      end
    end

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      flags_in = FLAGS_T'(4'($urandom_range(0, 15)));
      flags_we = ($urandom_range(0, 3) == 0);
      push     = ($urandom_range(0, 3) == 0);
      pop      = ($urandom_range(0, 3) == 0);
      cond     = COND_T'(4'($urandom_range(0, 15)));
      br_valid = ($urandom_range(0, 1) == 1);
      br_ack   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/condition_flags_unit.md
CONDITION_FLAGS_UNIT -- requirements
Module: condition_flags_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, number of flag-save entries (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flags_in  input  FLAGS_T  flag vector from the ALU flags output.
REQ-005 SHALL have port flags_we  input  1  load flags_in into the flags register.
REQ-006 SHALL have port push  input  1  save the current flags register onto the stack.
REQ-007 SHALL have port pop  input  1  restore the flags register from the stack top.
REQ-008 SHALL have port cond  input  COND_T  branch condition code, sampled on acceptance.
REQ-009 SHALL have port br_valid  input  1  branch-evaluation request.
REQ-010 SHALL have port br_ready  output  1  unit can accept a request.
REQ-011 SHALL have port br_done  output  1  result available on br_taken.
REQ-012 SHALL have port br_taken  output  1  evaluated condition result.
REQ-013 SHALL have port br_ack  input  1  consumer has taken the result.
REQ-014 SHALL have port flags_out  output  FLAGS_T  current flags register.
REQ-015 SHALL have port stack_count  output  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
REQ-016 SHALL have port stack_err  output  1  sticky overflow/underflow/conflict error.

Function
REQ-017 SHALL define F_next (the flags register value for the next cycle) with this priority: flags_in if flags_we; else the stack top if a legal pop; else hold.
REQ-018 SHALL, on a legal push, write the pre-update flags register to the stack.
- A push in the same cycle as flags_we saves the old value.
- flags_out takes flags_in.
REQ-019 SHALL, on a legal pop concurrent with flags_we, decrement stack_count and discard the popped entry.
REQ-020 SHALL ignore a push when stack_count==STACK_DEPTH, set stack_err, and leave stack contents unchanged.
REQ-021 SHALL ignore a pop when stack_count==0, set stack_err, and leave flags unchanged.
REQ-022 SHALL treat push and pop in the same cycle as a conflict: neither is performed, and stack_err is set.
REQ-023 SHALL implement a branch FSM with two states, IDLE and RESULT.
- br_ready = (state==IDLE).
- br_done = (state==RESULT).
REQ-024 SHALL accept a request in IDLE when br_valid=1, evaluate cond against F_next, register br_taken, and move to RESULT.
- Latency is one cycle from acceptance to br_done.
REQ-025 SHALL hold br_taken and br_done stable in RESULT until br_ack=1, then return to IDLE; no new request is accepted in that cycle.
REQ-026 SHALL evaluate conditions with z, n, c, v as fields of F_next:
- ALWAYS=1
- EQ=z, NE=!z
- CS=c, CC=!c
- MI=n, PL=!n
- VS=v, VC=!v
- LT=n^v, GE=!(n^v)
- GT=!z&!(n^v), LE=z|(n^v)
- NEVER=0
REQ-027 SHALL yield br_taken=0 for unused COND_T encodings.
REQ-028 SHALL leave the flags register and stack operations unaffected by branch FSM state.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear the flags register to FLAGS_T'(0), stack_count to 0 and stack_err to 0, and set the FSM to IDLE with br_taken=0.
REQ-030 SHALL drive br_ready=0 while rst is asserted; a request pending in RESULT is discarded by reset without br_done.
REQ-031 SHALL not require the stack storage array to be reset.

Structure
REQ-032 SHALL take WORD_SIZE and FLAGS_T from the shared instruction_set package.
REQ-033 SHALL add COND_T (4-bit enum of the REQ-026 codes) to the instruction_set package.
REQ-034 SHALL implement the stack as one sub-module, flags_stack (storage, count, full/empty); the condition evaluator is combinational logic inside the top.

Verification
REQ-035 SHALL cover: flags_we with flags_in={z=1}, br_valid with cond=EQ in the same cycle -> next cycle br_done=1, br_taken=1 (forwarding).
REQ-036 SHALL cover: flags {n=1,v=0}, cond=LT, br_ack held low 3 cycles -> br_taken=1 and br_done=1 stable for 3 cycles, br_ready=0 throughout.
REQ-037 SHALL cover: 4 pushes of distinct flags, a 5th push, then 5 pops -> count 4 with stack_err=1 after the 5th push; flags restored in LIFO order; 5th pop leaves flags unchanged.
REQ-038 SHALL cover: push and pop in the same cycle at count=2 -> count stays 2, stack_err=1.
REQ-039 SHALL cover: rst asserted in RESULT -> next cycle br_done=0, flags_out=0, stack_count=0, stack_err=0.
REQ-040 SHALL cover: all 16 cond codes against all 16 flag combinations -> br_taken matches the REQ-026 table.
